counter_4b_sequencer: RTL

Command-driven controller that sits directly upstream of the 4-bit counter and drives its enable, mode and parallel-load data. It accepts one command at a time over a valid/ready handshake. It runs the counter in the requested mode until a programmed number of ripple-carry (rco) events occurs, then reports completion with the captured count value. Parallel-load commands wait for the counter's load acknowledge, bounded by a timeout.

---
 rtl/counter_4b_sequencer_pkg.sv | 30 +++
 rtl/counter_4b_sequencer_event_counter.sv | 40 ++++
 rtl/counter_4b_sequencer.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/counter_4b_sequencer_pkg.sv
// Shared encodings for the 4-bit counter sequencer.
// Latency: n/a (types, constants and helpers only).
// Backpressure: n/a.
package counter_4b_sequencer_pkg;

  // Counter mode encodings as seen on cmd_mode / ctr_mode.
  typedef enum logic [1:0] {
    MODE_UP  = 2'b00,
    MODE_DN  = 2'b01,
    MODE_DN3 = 2'b10,
    MODE_LD  = 2'b11
  } ctr_mode_t;

  // Sequencer FSM states, 2-bit binary.
  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_LOAD = 2'b01,
    S_RUN  = 2'b10,
    S_DONE = 2'b11
  } seq_state_t;

  // The event counter needs one extra bit so that a target of 16 is representable.
  localparam int EVT_W = 5;

  // A programmed count of zero means a full 16-event run.
  function automatic logic [EVT_W-1:0] run_target(input logic [3:0] count);
    return (count == 4'd0) ? 5'd16 : {1'b0, count};
  endfunction

endpackage

// File: rtl/counter_4b_sequencer_event_counter.sv
// Generic up-counter with synchronous clear, increment and target-hit flag.
// Latency: count updates on the edge after inc; hit is combinational from inc and count.
// Backpressure: none; in saturating mode increments at all-ones are dropped.
//
// Ports:
//   clk, reset   clock and asynchronous active-low reset
//   clr          synchronous clear (wins over inc)
//   inc          count one event this cycle
//   target       value whose arrival raises hit
//   cnt          current count
//   hit          this increment makes cnt equal target
module seq_event_counter #(
  parameter int W   = 5,
  parameter bit SAT = 1'b0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  input  logic [W-1:0] target,
  output logic [W-1:0] cnt,
  output logic         hit
);

  logic at_max;

  assign at_max = (cnt == {W{1'b1}});
  assign hit    = inc && ((cnt + W'(1)) == target);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !(SAT && at_max)) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/counter_4b_sequencer.sv
// Command sequencer driving a 4-bit counter: run-until-N-rco or parallel load with ack timeout.
// Latency: outputs change on the accept edge; done pulses on the edge the run/load completes.
// Backpressure: cmd_ready is low from accept until one cycle after done; upstream holds cmd.
//
// Ports:
//   clk, reset                        clock, asynchronous active-low reset
//   cmd_valid/cmd_ready               command handshake
//   cmd_mode, cmd_data, cmd_count     mode, load data, rco events per run (0 = 16)
//   ctr_rco, ctr_load, ctr_Q          counter wrap pulse, load ack, current value
//   ctr_enable, ctr_mode, ctr_D       counter controls
//   busy, done, err, q_last           status, completion pulse, sticky load timeout, captured Q
//   rco_total                         saturating count of rco seen while enabled
module counter_4b_sequencer #(
  parameter int TIMEOUT   = 8,
  parameter int RCO_TOT_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [1:0]           cmd_mode,
  input  logic [3:0]           cmd_data,
  input  logic [3:0]           cmd_count,
  input  logic                 ctr_rco,
  input  logic                 ctr_load,
  input  logic [3:0]           ctr_Q,
  output logic                 ctr_enable,
  output logic [1:0]           ctr_mode,
  output logic [3:0]           ctr_D,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [3:0]           q_last,
  output logic [RCO_TOT_W-1:0] rco_total
);

  import counter_4b_sequencer_pkg::*;

  localparam int                WAIT_W    = $clog2(TIMEOUT) + 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  seq_state_t        state;
  logic [WAIT_W-1:0] wait_cnt;
  logic [EVT_W-1:0]  evt_target;
  logic              evt_clr;
  logic              evt_inc;
  logic              evt_hit;
  logic [EVT_W-1:0]  evt_cnt_unused;
  logic              tot_hit_unused;
  logic              accept;
  logic              wait_expired;
  logic              finish;

  assign accept       = (state == S_IDLE) && cmd_valid && cmd_ready;
  assign wait_expired = (wait_cnt == WAIT_LAST);
  // An ack arriving on the timeout cycle completes the load successfully.
  assign finish = ((state == S_LOAD) && (ctr_load || wait_expired)) ||
                  ((state == S_RUN) && evt_hit);

  // Events only count toward a command while in RUN; cleared whenever idle.
  assign evt_clr = (state == S_IDLE);
  assign evt_inc = (state == S_RUN) && ctr_rco;

  seq_event_counter #(.W(EVT_W), .SAT(1'b0)) u_evt (
    .clk    (clk),
    .reset  (reset),
    .clr    (evt_clr),
    .inc    (evt_inc),
    .target (evt_target),
    .cnt    (evt_cnt_unused),
    .hit    (evt_hit)
  );

  // Statistic counts on the registered enable, so a pulse landing on the
  // edge that leaves RUN is still included.
  seq_event_counter #(.W(RCO_TOT_W), .SAT(1'b1)) u_tot (
    .clk    (clk),
    .reset  (reset),
    .clr    (1'b0),
    .inc    (ctr_rco && ctr_enable),
    .target ({RCO_TOT_W{1'b1}}),
    .cnt    (rco_total),
    .hit    (tot_hit_unused)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      wait_cnt   <= '0;
      evt_target <= '0;
      cmd_ready  <= 1'b0;
      ctr_enable <= 1'b0;
      ctr_mode   <= 2'b00;
      ctr_D      <= 4'b0000;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      q_last     <= 4'b0000;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            cmd_ready  <= 1'b0;
            busy       <= 1'b1;
            ctr_enable <= 1'b1;
            ctr_mode   <= cmd_mode;
            err        <= 1'b0;
            wait_cnt   <= '0;
            evt_target <= run_target(cmd_count);
            if (cmd_mode == MODE_LD) begin
              ctr_D <= cmd_data;
              state <= S_LOAD;
            end else begin
              state <= S_RUN;
            end
          end else begin
            cmd_ready <= 1'b1;
          end
        end
        S_LOAD: begin
          if (!finish) begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end else if (!ctr_load) begin
            err <= 1'b1;
          end
        end
        S_RUN: begin
        end
        S_DONE: begin
          state     <= S_IDLE;
          busy      <= 1'b0;
          cmd_ready <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase

      if (finish) begin
        state      <= S_DONE;
        done       <= 1'b1;
        ctr_enable <= 1'b0;
        q_last     <= ctr_Q;
      end
    end
  end

endmodule
